dma_bus_arbiter: RTL and testbench

//  Arbitrates the shared memory bus between the CPU pipeline (MEM stage) and the DMA engine.

---
 rtl/dma_bus_arbiter_if.sv | 23 ++
 rtl/dma_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_dma_bus_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dma_bus_arbiter_if.sv
// Bus-ownership handshake between the CPU MEM stage / DMA engine and the arbiter.
// master = requester side (CPU + DMA), slave = arbiter.
interface dma_bus_arbiter_if;
    logic       cpu_req;
    logic       cpu_done;
    logic       dma_req;
    logic       dma_last;
    logic       gnt_cpu;
    logic       gnt_dma;
    logic       cpu_stall;
    logic       dma_preempt;
    logic [1:0] arb_state;

    modport master (
        output cpu_req, cpu_done, dma_req, dma_last,
        input  gnt_cpu, gnt_dma, cpu_stall, dma_preempt, arb_state
    );

    modport slave (
        input  cpu_req, cpu_done, dma_req, dma_last,
        output gnt_cpu, gnt_dma, cpu_stall, dma_preempt, arb_state
    );
endinterface

// File: rtl/dma_bus_arbiter.sv
// Shared memory bus arbiter between the CPU MEM stage and the DMA engine, with a
// dead handoff cycle between owners, bounded DMA bursts and CPU starvation release.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | bus unowned, waiting for a request (CPU wins ties)
//   CPU     | CPU owns bus until cpu_done or cpu_req drops
//   DMA     | DMA owns bus until voluntary release, burst or starve limit
//   HANDOFF | one dead cycle, no grant; picks the next owner
module dma_bus_arbiter #(
    parameter int MAX_BURST  = 4,
    parameter int CPU_STARVE = 3,
    parameter int CNT_W      = 5
) (
    input  logic               clk,
    input  logic               rst,
    dma_bus_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU     = 2'd1,
        ST_DMA     = 2'd2,
        ST_HANDOFF = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam logic [CNT_W-1:0] BURST_TC  = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] STARVE_TC = CNT_W'(CPU_STARVE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_next;
    owner_t           last_owner, last_owner_next;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_next;
    logic [CNT_W-1:0] starve_cnt, starve_cnt_next;
    logic             preempt, preempt_next;

    logic             dma_voluntary;
    logic             dma_limit;
    logic             cpu_release;

    // Limit compares use the count before this cycle's increment, so the exit edge
    // closes out exactly MAX_BURST / CPU_STARVE grant cycles.
    assign dma_voluntary = bus.dma_last | ~bus.dma_req;
    assign dma_limit     = (burst_cnt == BURST_TC) |
                           (bus.cpu_req & (starve_cnt == STARVE_TC));
    assign cpu_release   = bus.cpu_done | ~bus.cpu_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_owner <= OWN_CPU;
            burst_cnt  <= '0;
            starve_cnt <= '0;
            preempt    <= 1'b0;
        end else begin
            state      <= state_next;
            last_owner <= last_owner_next;
            burst_cnt  <= burst_cnt_next;
            starve_cnt <= starve_cnt_next;
            preempt    <= preempt_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_owner_next = last_owner;
        burst_cnt_next  = '0;
        starve_cnt_next = '0;
        preempt_next    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.cpu_req) begin
                    state_next = ST_CPU;
                end else if (bus.dma_req) begin
                    state_next = ST_DMA;
                end
            end

            ST_CPU: begin
                if (cpu_release) begin
                    state_next      = bus.dma_req ? ST_HANDOFF : ST_IDLE;
                    last_owner_next = OWN_CPU;
                end
            end

            ST_DMA: begin
                if (dma_voluntary || dma_limit) begin
                    state_next      = (bus.cpu_req || bus.dma_req) ? ST_HANDOFF : ST_IDLE;
                    last_owner_next = OWN_DMA;
                    // A voluntary release wins even if a limit fires on the same edge.
                    preempt_next    = dma_limit & ~dma_voluntary;
                end else begin
                    burst_cnt_next  = burst_cnt + CNT_ONE;
                    starve_cnt_next = bus.cpu_req ? (starve_cnt + CNT_ONE) : starve_cnt;
                end
            end

            ST_HANDOFF: begin
                if (last_owner == OWN_CPU) begin
                    if (bus.dma_req)      state_next = ST_DMA;
                    else if (bus.cpu_req) state_next = ST_CPU;
                    else                  state_next = ST_IDLE;
                end else begin
                    if (bus.cpu_req)      state_next = ST_CPU;
                    else if (bus.dma_req) state_next = ST_DMA;
                    else                  state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.gnt_cpu     = (state == ST_CPU);
    assign bus.gnt_dma     = (state == ST_DMA);
    assign bus.cpu_stall   = bus.cpu_req & ~bus.gnt_cpu;
    assign bus.dma_preempt = preempt;
    assign bus.arb_state   = state;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: a per-cycle vector table plus hand-written
// sequences for the starvation bound and reset mid-tenure.
module tb_dma_bus_arbiter;

    logic clk;
    logic rst;

    dma_bus_arbiter_if bus();

    dma_bus_arbiter #(
        .MAX_BURST  (4),
        .CPU_STARVE (3),
        .CNT_W      (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in  = {cpu_req, cpu_done, dma_req, dma_last}
    // out = {gnt_cpu, gnt_dma, cpu_stall, dma_preempt}
    typedef struct packed {
        logic [3:0] in;
        logic [3:0] out;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] in, input logic [3:0] out, input logic [1:0] st);
        vec_t v;
        v.in  = in;
        v.out = out;
        v.st  = st;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] in);
        bus.cpu_req  = in[3];
        bus.cpu_done = in[2];
        bus.dma_req  = in[1];
        bus.dma_last = in[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wait_cycles;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        drive(4'b0000);

        // Both request; CPU wins, done on 3rd grant cycle, handoff to DMA
        add(4'b0000, 4'b0000, 2'd0);
        add(4'b1010, 4'b0010, 2'd0);
        add(4'b1010, 4'b1000, 2'd1);
        add(4'b1010, 4'b1000, 2'd1);
        add(4'b1110, 4'b1000, 2'd1);
        add(4'b0010, 4'b0000, 2'd3);
        // DMA alone hits the 4-cycle burst limit, preempted, granted again
        add(4'b0010, 4'b0100, 2'd2);
        add(4'b0010, 4'b0100, 2'd2);
        add(4'b0010, 4'b0100, 2'd2);
        add(4'b0010, 4'b0100, 2'd2);
        add(4'b0010, 4'b0001, 2'd3);
        // CPU requests from 1st DMA cycle: 3 DMA cycles, handoff, CPU in 5th
        add(4'b1010, 4'b0110, 2'd2);
        add(4'b1010, 4'b0110, 2'd2);
        add(4'b1010, 4'b0110, 2'd2);
        add(4'b1010, 4'b0011, 2'd3);
        add(4'b1010, 4'b1000, 2'd1);
        add(4'b1110, 4'b1000, 2'd1);
        add(4'b0010, 4'b0000, 2'd3);
        // dma_last on 2nd grant cycle, no requests left -> IDLE
        add(4'b0010, 4'b0100, 2'd2);
        add(4'b0001, 4'b0100, 2'd2);
        add(4'b0000, 4'b0000, 2'd0);
        // done/last ignored while not granted
        add(4'b0101, 4'b0000, 2'd0);
        add(4'b0000, 4'b0000, 2'd0);
        // dma_last coincident with burst limit -> not a preemption
        add(4'b0010, 4'b0000, 2'd0);
        add(4'b0010, 4'b0100, 2'd2);
        add(4'b0010, 4'b0100, 2'd2);
        add(4'b0010, 4'b0100, 2'd2);
        add(4'b0011, 4'b0100, 2'd2);
        add(4'b0000, 4'b0000, 2'd3);
        add(4'b0000, 4'b0000, 2'd0);
        // cpu_req dropping without cpu_done ends the CPU tenure
        add(4'b1000, 4'b0010, 2'd0);
        add(4'b1000, 4'b1000, 2'd1);
        add(4'b0000, 4'b1000, 2'd1);
        add(4'b0000, 4'b0000, 2'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].in);
            #1;
            check($sformatf("v%0d gnt_cpu", i),     {1'b0, bus.gnt_cpu},     {1'b0, vecs[i].out[3]});
            check($sformatf("v%0d gnt_dma", i),     {1'b0, bus.gnt_dma},     {1'b0, vecs[i].out[2]});
            check($sformatf("v%0d cpu_stall", i),   {1'b0, bus.cpu_stall},   {1'b0, vecs[i].out[1]});
            check($sformatf("v%0d dma_preempt", i), {1'b0, bus.dma_preempt}, {1'b0, vecs[i].out[0]});
            check($sformatf("v%0d arb_state", i),   bus.arb_state,           vecs[i].st);
            tick();
        end

        // CPU arriving mid-tenure waits at most CPU_STARVE+1 = 4 cycles
        drive(4'b0010);
        tick();
        check("starve dma_c1 gnt_dma", {1'b0, bus.gnt_dma}, 2'd1);
        tick();
        drive(4'b1010);
        wait_cycles = 0;
        #1;
        while (!bus.gnt_cpu && wait_cycles < 10) begin
            wait_cycles++;
            tick();
        end
        check("starve wait_cycles", wait_cycles[1:0] | {2{wait_cycles > 3 && wait_cycles != 4}},
              2'd0);
        check("starve wait_exact", {1'b0, wait_cycles == 4}, 2'd1);
        drive(4'b0000);
        tick();
        check("starve back_idle", bus.arb_state, 2'd0);

        // Reset pulled during 2nd DMA cycle, then CPU granted one cycle after release
        drive(4'b0010);
        tick();
        tick();
        check("rst pre gnt_dma", {1'b0, bus.gnt_dma}, 2'd1);
        rst = 1'b0;
        #1;
        check("rst gnt_dma", {1'b0, bus.gnt_dma}, 2'd0);
        check("rst arb_state", bus.arb_state, 2'd0);
        check("rst dma_preempt", {1'b0, bus.dma_preempt}, 2'd0);
        drive(4'b1000);
        tick();
        check("rst held arb_state", bus.arb_state, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rst release gnt_cpu", {1'b0, bus.gnt_cpu}, 2'd1);
        check("rst release arb_state", bus.arb_state, 2'd1);
        drive(4'b0000);
        tick();
        check("final idle", bus.arb_state, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
